// File: rtl/booth_mult4_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   state_t      : controller states (IDLE accepts work, CALC iterates)
//   BOOTH_*      : {Q[0], q_m1} recoding values selecting the per-step action
//   N_DEFAULT    : default operand width
package booth_mult4_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   localparam logic [1:0] BOOTH_NOP0 = 2'b00;  // run of zeros: no action
   localparam logic [1:0] BOOTH_ADD  = 2'b01;  // end of a run of ones: A += M
   localparam logic [1:0] BOOTH_SUB  = 2'b10;  // start of a run of ones: A -= M
   localparam logic [1:0] BOOTH_NOP1 = 2'b11;  // inside a run of ones: no action

   localparam int N_DEFAULT = 4;

endpackage

// File: rtl/booth_mult4_addsub.sv
// addsub_stage: W-bit ripple-carry add/subtract, purely combinational.
//   a, b  : operands
//   mode  : 0 = a + b, 1 = a - b (b inverted, carry-in = 1)
//   sum   : W-bit result; carry-out is dropped, so results wrap modulo 2^W
module addsub_stage #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         mode,
   output logic [W-1:0] sum
);

   logic [W-1:0] bx;
   logic [W-1:0] c;

   assign bx   = b ^ {W{mode}};
   assign c[0] = mode;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i] = a[i] ^ bx[i] ^ c[i];
      // The carry out of the top bit is never built.
      if (i < W - 1) begin : g_carry
         assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
   end

endmodule

// File: rtl/booth_mult4.sv
// booth_mult4: sequential signed multiplier, one radix-2 Booth step per cycle.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : begin a multiply; only honoured while ready=1
//   multiplicand (M)    : signed N-bit operand, sampled with start
//   multiplier   (Q)    : signed N-bit operand, sampled with start
//   ready               : idle and able to accept start
//   done                : one-cycle pulse after a new product has been loaded
//   product             : signed 2N-bit M*Q, held until the next completion
// Latency is fixed at N edges from the start-sampling edge to done.
module booth_mult4
   import booth_mult4_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           ready,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   state_t        state, state_nxt;
   logic [N:0]    a_r, m_r;
   logic [N-1:0]  q_r;
   logic          q_m1;
   logic [CW-1:0] count;

   logic [1:0]    code;
   logic          sub;
   logic [N:0]    sum, a_sel, a_shf;
   logic [N-1:0]  q_shf;
   logic          last;

   // A is N+1 bits wide so that subtracting M = -2^(N-1) cannot overflow.
   addsub_stage #(.W(N + 1)) u_addsub (
      .a    (a_r),
      .b    (m_r),
      .mode (sub),
      .sum  (sum)
   );

   always_comb begin
      code  = {q_r[0], q_m1};
      sub   = (code == BOOTH_SUB);
      a_sel = (code == BOOTH_ADD || code == BOOTH_SUB) ? sum : a_r;
      // Arithmetic right shift of {A, Q, q_m1}
      a_shf = {a_sel[N], a_sel[N:1]};
      q_shf = {a_sel[0], q_r[N-1:1]};
      last  = (count == CW'(1));
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = CALC;
         end
         CALC: if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         m_r     <= '0;
         q_r     <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               m_r   <= {multiplicand[N-1], multiplicand};
               a_r   <= '0;
               q_r   <= multiplier;
               q_m1  <= 1'b0;
               count <= CW'(N);
            end
            CALC: begin
               a_r   <= a_shf;
               q_r   <= q_shf;
               q_m1  <= q_r[0];
               count <= count - CW'(1);
               if (last) begin
                  // Product taken from the post-shift value of the final step
                  product <= {a_shf[N-1:0], q_shf};
                  done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult4.sv
module tb_booth_mult4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] multiplicand;
   logic [3:0] multiplier;
   logic       ready;
   logic       done;
   logic [7:0] product;

   int n_cmp = 0;
   int n_err = 0;

   booth_mult4 #(.N(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .ready        (ready),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain signed integer multiply, truncated to 8 bits.
   function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
      int mi, qi, p;
      mi = (m[3]) ? int'(m) - 16 : int'(m);
      qi = (q[3]) ? int'(q) - 16 : int'(q);
      p  = mi * qi;
      return p[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction: checks latency, ready low while busy, result, single pulse.
   task automatic run_mult(input logic [3:0] m, input logic [3:0] q,
                           input logic [7:0] exp, input string tag);
      int lat;
      bit busy_bad;
      check({tag, " ready_before"}, 32'(ready), 32'd1);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk); #1;            // E0 has been sampled
      start        = 1'b0;
      multiplicand = 4'($urandom);   // operands are don't-care after E0
      multiplier   = 4'($urandom);
      lat      = 0;
      busy_bad = 1'b0;
      while (done !== 1'b1 && lat < 20) begin
         if (ready !== 1'b0) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " ready_low"}, 32'(busy_bad), 32'd0);
      check({tag, " product"}, 32'(product), 32'(exp));
      @(posedge clk); #1;
      check({tag, " done_single"}, 32'(done), 32'd0);
   endtask

   initial begin
      int npulse;
      bit seen;
      logic [3:0] rm, rq;

      rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
      #1;
      check("reset ready", 32'(ready), 32'd1);
      check("reset done", 32'(done), 32'd0);
      check("reset product", 32'(product), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_mult(4'd3, 4'd5, 8'h0F, "m3q5");
      run_mult(4'h8, 4'h8, 8'h40, "m-8q-8");
      run_mult(4'h8, 4'h7, 8'hC8, "m-8q7");
      run_mult(4'h0, 4'hF, 8'h00, "m0q-1");
      run_mult(4'hF, 4'hF, 8'h01, "m-1q-1");

      // Start while busy is ignored; start held high is taken at E0+5.
      multiplicand = 4'd2; multiplier = 4'd3; start = 1'b1;
      @(posedge clk); #1;            // E0
      start = 1'b0;
      npulse = 0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) npulse++;
         if (e == 3) check("busy ignore ready", 32'(ready), 32'd0);
         if (e == 4) begin
            check("busy ignore done", 32'(done), 32'd1);
            check("busy ignore product", 32'(product), 32'h06);
         end
         if (e == 5) begin
            check("held start ready", 32'(ready), 32'd0);
            check("held start done", 32'(done), 32'd0);
            check("held start hold", 32'(product), 32'h06);
         end
         if (e == 9) begin
            check("held start done2", 32'(done), 32'd1);
            check("held start product", 32'(product), 32'h19);
         end
         if (e == 1) begin start = 1'b1; multiplicand = 4'd5; multiplier = 4'd5; end
         if (e == 5) start = 1'b0;
      end
      check("busy pulse count", 32'(npulse), 32'd2);

      // Asynchronous reset at iteration 2 aborts without done.
      multiplicand = 4'd7; multiplier = 4'd7; start = 1'b1;
      @(posedge clk); #1;            // E0
      start = 1'b0;
      @(posedge clk); #1;            // iteration 1
      @(posedge clk); #2;            // iteration 2, mid-cycle
      rst_n = 1'b0;
      #1;
      check("abort done", 32'(done), 32'd0);
      check("abort product", 32'(product), 32'd0);
      check("abort ready", 32'(ready), 32'd1);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("abort no pulse", 32'(seen), 32'd0);
      run_mult(4'd7, 4'd7, 8'h31, "after reset");

      for (int k = 0; k < 24; k++) begin
         rm = 4'($urandom);
         rq = 4'($urandom);
         run_mult(rm, rq, ref_prod(rm, rq), "random");
      end

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run_mult(4'(i), 4'(j), ref_prod(4'(i), 4'(j)), "sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/booth_mult4.md
BOOTH_MULT4 -- requirements
Module: booth_mult4

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand width in bits; only N=4 is verified.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only when ready=1.
REQ-005 SHALL have port multiplicand  input  N  signed two's-complement operand M; sampled with start.
REQ-006 SHALL have port multiplier  input  N  signed two's-complement operand Q; sampled with start.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a new product.
REQ-009 SHALL have port product  output  2N  signed product M*Q; held until the next completion.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (ready=1) and CALC (ready=0).
REQ-011 In IDLE, start=1 at rising edge E0 SHALL latch the following, then enter CALC:
- M, sign-extended to N+1 bits
- A=0 (N+1 bits), Q=multiplier
- q_m1=0, count=N
REQ-012 SHALL perform exactly one radix-2 Booth iteration per CALC cycle, selected by {Q[0],q_m1}:
- 10: A=A-M
- 01: A=A+M
- 00/11: A unchanged
REQ-013 SHALL then arithmetic-shift {A,Q,q_m1} right by one, replicating A's sign bit, and decrement count.
REQ-014 SHALL perform all add/subtract in N+1 bits, discard the carry-out, and never flag overflow; this makes M=-2^(N-1) correct.
REQ-015 On the edge completing iteration N (edge E0+N), SHALL do all of:
- load product with the low 2N bits of {A,Q}
- drive done=1 for exactly the following cycle
- return to IDLE
REQ-016 Latency SHALL be fixed at N clock edges from start sample to done, independent of operand values.
REQ-017 SHALL ignore start while in CALC; latched operands SHALL NOT change mid-operation.
REQ-018 SHALL accept a new start at edge E0+N+1, giving back-to-back throughput of one product per N+1 cycles.
REQ-019 SHALL leave product unchanged at all edges except the completion edge.
REQ-020 Operand inputs SHALL be don't-care except at the start-sampling edge.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock, force all of:
- state=IDLE, ready=1, done=0, product=0
- A=0, Q=0, M=0, q_m1=0, count=0
REQ-022 Reset asserted mid-operation SHALL abort the multiply with no done pulse; the first start after reset release SHALL behave as REQ-011.

Structure
REQ-023 A shared package SHALL hold the following, and nothing block-private:
- the FSM state enumeration (IDLE, CALC)
- the Booth-code constants (00, 01, 10, 11)
- the default width N
REQ-024 SHALL instantiate exactly one sub-module, addsub_stage: an (N+1)-bit ripple add/subtract unit.
- inputs: a, b, mode (0=add, 1=subtract via b XOR mode with carry-in=mode)
- outputs: sum
- purely combinational; all registers live in booth_mult4

Verification
REQ-025 Bench SHALL cover: M=3, Q=5, start -> done exactly 4 edges after start edge, product=8'h0F, ready low for those 4 cycles.
REQ-026 Bench SHALL cover: M=-8 (4'h8), Q=-8 (4'h8) -> product=8'h40 (+64); also M=-8, Q=7 -> product=8'hC8 (-56).
REQ-027 Bench SHALL cover: M=0, Q=-1 -> product=8'h00; then M=-1, Q=-1 -> product=8'h01.
REQ-028 Bench SHALL cover the following, in order:
- start M=2, Q=3, then start=1 with M=5, Q=5 two cycles later -> second request ignored, product=8'h06, single done pulse
- start held high after done -> new multiply begins at edge E0+5 with correct result
REQ-029 Bench SHALL cover: rst_n pulsed low at iteration 2 of M=7, Q=7 -> done=0, product=0, ready=1 asynchronously; next start M=7, Q=7 -> product=8'h31.
REQ-030 Bench SHALL compare all 256 operand pairs against a signed reference multiply; zero mismatches allowed.
